sram_req_bridge: RTL and testbench

//  Valid/ready front end for the single-port, 1-cycle-latency tagged SRAM macro wrapper.
//  - Accepts word requests (read/write, data + user/tag, byte enables) from the AXI tag-controller datapath.
//  - Issues them to the SRAM port.
//  - Buffers read data into a response FIFO, so downstream backpressure never loses data.
//  - Sustains 1 request/cycle when RSP_DEPTH >= 3.

---
 rtl/sram_req_bridge.sv | 157 +++++++++++++++
 tb/tb_sram_req_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_bridge.sv
// sram_req_bridge
// Valid/ready front end for a single-port, 1-cycle-latency tagged SRAM.
// Requests go straight to the SRAM in the cycle they are accepted. Read data
// comes back one cycle later and is parked in a small response FIFO. A credit
// counter covers the in-flight slot plus FIFO occupancy, so a returning
// response always has room and downstream backpressure never drops data.
// Optional feature macro: SRAM_BRIDGE_WRITE_RSP_EN
//   defined   -> every write also returns a response (rsp_we_o=1, zero data)
//   undefined -> writes are fire-and-forget and take no credit
module sram_req_bridge #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int NUM_WORDS  = 1024,
   parameter int RSP_DEPTH  = 3,
   localparam int ADDR_W    = $clog2(NUM_WORDS),
   localparam int BE_W      = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [USER_WIDTH-1:0] req_wuser_i,
   input  logic [BE_W-1:0]       req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_we_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [USER_WIDTH-1:0] rsp_ruser_o,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [ADDR_W-1:0]     sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic [USER_WIDTH-1:0] sram_wuser_o,
   output logic [BE_W-1:0]       sram_be_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i,
   input  logic [USER_WIDTH-1:0] sram_ruser_i
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(RSP_DEPTH - 1);

   logic                  infl_q, infl_we_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
   logic [DATA_WIDTH-1:0] dataMem_q [RSP_DEPTH];
   logic [USER_WIDTH-1:0] userMem_q [RSP_DEPTH];
`ifdef SRAM_BRIDGE_WRITE_RSP_EN
   logic                  weMem_q [RSP_DEPTH];
`endif

   logic                  reqReady, acc, needsRsp, push, pop, empty, full;
   logic [DATA_WIDTH-1:0] pushData;
   logic [USER_WIDTH-1:0] pushUser;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR_C) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready depends only on registered credit, never on rsp_ready_i.
   assign reqReady    = !rst_i && (cnt_q < DEPTH_C);
   assign req_ready_o = reqReady;
   assign acc         = req_valid_i && reqReady;

`ifdef SRAM_BRIDGE_WRITE_RSP_EN
   assign needsRsp = 1'b1;
`else
   assign needsRsp = !req_we_i;
`endif

   assign sram_req_o   = acc;
   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_wuser_o = req_wuser_i;
   assign sram_be_o    = req_be_i;

   // The SRAM answers the cycle after the request, so the in-flight flag is the push strobe.
   assign push     = infl_q;
   assign pushData = infl_we_q ? '0 : sram_rdata_i;
   assign pushUser = infl_we_q ? '0 : sram_ruser_i;

   assign empty       = (occ_q == '0);
   assign full        = (occ_q == DEPTH_C);
   assign rsp_valid_o = !rst_i && !empty;
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign rsp_rdata_o = dataMem_q[rdPtr_q];
   assign rsp_ruser_o = userMem_q[rdPtr_q];
`ifdef SRAM_BRIDGE_WRITE_RSP_EN
   assign rsp_we_o    = weMem_q[rdPtr_q];
`else
   assign rsp_we_o    = 1'b0;
`endif

   // Next-state for credit counter, FIFO occupancy and the modulo-depth pointers.
   always_comb begin
      cnt_d   = cnt_q;
      occ_d   = occ_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (acc && needsRsp) begin
         cnt_d = cnt_d + CNT_W'(1);
      end
      if (pop) begin
         cnt_d   = cnt_d - CNT_W'(1);
         occ_d   = occ_d - CNT_W'(1);
         rdPtr_d = nextPtr(rdPtr_q);
      end
      if (push) begin
         occ_d   = occ_d + CNT_W'(1);
         wrPtr_d = nextPtr(wrPtr_q);
      end
   end

   // Control state; reset drops anything in flight or buffered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         infl_q    <= 1'b0;
         infl_we_q <= 1'b0;
         cnt_q     <= '0;
         occ_q     <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
      end else begin
         infl_q    <= acc && needsRsp;
         infl_we_q <= req_we_i;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
      end
   end

   // Response storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (push) begin
         dataMem_q[wrPtr_q] <= pushData;
         userMem_q[wrPtr_q] <= pushUser;
`ifdef SRAM_BRIDGE_WRITE_RSP_EN
         weMem_q[wrPtr_q]   <= infl_we_q;
`endif
      end
   end

`ifndef SYNTHESIS
   noPushWhenFull:  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
   noPopWhenEmpty:  assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));
   creditInRange:   assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Testbench for sram_req_bridge: a behavioural SRAM, a reference memory and a
// queue of pending responses predict every output cycle by cycle; directed
// sequences add literal expectations for data, throughput and reset.
module tb_sram_req_bridge;

   localparam int DEPTH = 3;
`ifdef SRAM_BRIDGE_WRITE_RSP_EN
   localparam int WR_RSP = 1;
`else
   localparam int WR_RSP = 0;
`endif

   typedef struct {
      logic        we;
      logic [63:0] data;
      logic [0:0]  user;
      int          readyCycle;
   } rspEntry_t;

   logic        clk = 1'b0;
   logic        rstI, reqValid, reqWe, rspReady;
   logic [9:0]  reqAddr;
   logic [63:0] reqWdata;
   logic [0:0]  reqWuser;
   logic [7:0]  reqBe;

   logic        req_ready_o, rsp_valid_o, rsp_we_o;
   logic [63:0] rsp_rdata_o;
   logic [0:0]  rsp_ruser_o;
   logic        sram_req_o, sram_we_o;
   logic [9:0]  sram_addr_o;
   logic [63:0] sram_wdata_o;
   logic [0:0]  sram_wuser_o;
   logic [7:0]  sram_be_o;
   logic [63:0] sramRdata;
   logic [0:0]  sramRuser;

   logic [63:0] sramMem [1024];
   logic [0:0]  sramUser [1024];
   logic [63:0] refMem [1024];
   logic [0:0]  refUser [1024];

   rspEntry_t   expQ[$];
   logic [63:0] obsData[$];
   logic [0:0]  obsUser[$];
   logic        obsWe[$];

   int vectorCount = 0;
   int missCount   = 0;
   int cycle       = 0;
   int accCount    = 0;
   int popCount    = 0;
   int stallCount  = 0;
   int lastAccCycle = 0;
   int lastPopCycle = 0;
   logic expReady, expValid;
   rspEntry_t newEntry;

   sram_req_bridge dut (
      .clk_i(clk), .rst_i(rstI),
      .req_valid_i(reqValid), .req_ready_o(req_ready_o), .req_we_i(reqWe),
      .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_wuser_i(reqWuser), .req_be_i(reqBe),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rspReady), .rsp_we_o(rsp_we_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_ruser_o(rsp_ruser_o),
      .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_wdata_o(sram_wdata_o), .sram_wuser_o(sram_wuser_o), .sram_be_o(sram_be_o),
      .sram_rdata_i(sramRdata), .sram_ruser_i(sramRuser)
   );

   // Free-running clock and cycle index.
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   // Behavioural SRAM with byte-enable writes and one cycle of read latency.
   always @(posedge clk) begin
      if (sram_req_o) begin
         if (sram_we_o) begin
            for (int b = 0; b < 8; b++)
               if (sram_be_o[b]) sramMem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            if (sram_be_o != 8'h00) sramUser[sram_addr_o] <= sram_wuser_o;
         end else begin
            sramRdata <= sramMem[sram_addr_o];
            sramRuser <= sramUser[sram_addr_o];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Reference model: pending responses form an in-order queue; a slot is a credit,
   // and each response becomes visible two cycles after its request was taken.
   always @(negedge clk) begin
      if (rstI) begin
         checkOutput("reset_req_ready", req_ready_o, 1'b0);
         checkOutput("reset_sram_req", sram_req_o, 1'b0);
         checkOutput("reset_rsp_valid", rsp_valid_o, 1'b0);
         expQ.delete();
      end else begin
         expReady = (expQ.size() < DEPTH);
         expValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cycle);
         if (reqValid && !req_ready_o) stallCount++;
         checkOutput("req_ready", req_ready_o, expReady);
         checkOutput("sram_req", sram_req_o, reqValid && expReady);
         if (reqValid && expReady) begin
            checkOutput("sram_we", sram_we_o, reqWe);
            checkOutput("sram_addr", sram_addr_o, reqAddr);
            checkOutput("sram_wdata", sram_wdata_o, reqWdata);
            checkOutput("sram_wuser", sram_wuser_o, reqWuser);
            checkOutput("sram_be", sram_be_o, reqBe);
         end
         checkOutput("rsp_valid", rsp_valid_o, expValid);
         if (expValid && rsp_valid_o) begin
            checkOutput("rsp_we", rsp_we_o, expQ[0].we);
            checkOutput("rsp_rdata", rsp_rdata_o, expQ[0].data);
            checkOutput("rsp_ruser", rsp_ruser_o, expQ[0].user);
         end
         if (expValid && rspReady) begin
            void'(expQ.pop_front());
            obsData.push_back(rsp_rdata_o);
            obsUser.push_back(rsp_ruser_o);
            obsWe.push_back(rsp_we_o);
            popCount++;
            lastPopCycle = cycle;
         end
         if (reqValid && expReady) begin
            accCount++;
            lastAccCycle = cycle;
            if (!reqWe || WR_RSP == 1) begin
               newEntry.we         = reqWe;
               newEntry.data       = reqWe ? 64'h0 : refMem[reqAddr];
               newEntry.user       = reqWe ? 1'b0 : refUser[reqAddr];
               newEntry.readyCycle = cycle + 2;
               expQ.push_back(newEntry);
            end
            if (reqWe) begin
               for (int b = 0; b < 8; b++)
                  if (reqBe[b]) refMem[reqAddr][8*b +: 8] = reqWdata[8*b +: 8];
               if (reqBe != 8'h00) refUser[reqAddr] = reqWuser;
            end
         end
      end
   end

   // Presents one request and holds it until accepted; returns just after the accepting edge.
   task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [63:0] wdata,
                                input logic [0:0] wuser, input logic [7:0] be);
      int n;
      reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqWuser = wuser; reqBe = be;
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) checkOutput("accept_timeout", req_ready_o, 1'b1);
      @(posedge clk); #1;
      reqValid = 1'b0;
   endtask

   task automatic waitPops(input string name, input int target, input int bound);
      int n;
      n = 0;
      while (popCount < target && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, popCount, target);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base, accBase, startCycle, sz;
      for (int i = 0; i < 1024; i++) begin
         sramMem[i] = '0; sramUser[i] = '0; refMem[i] = '0; refUser[i] = '0;
      end
      sramRdata = '0; sramRuser = '0;
      rstI = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
      reqWuser = '0; reqBe = '0; rspReady = 1'b1;
      repeat (3) @(posedge clk);
      #1 rstI = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", req_ready_o, 1'b1);
      @(posedge clk); #1;

      $display("[TB] full write then read back");
      base = popCount;
      applyStimulus(1'b1, 10'h010, 64'hDEADBEEF_CAFEF00D, 1'b1, 8'hFF);
      applyStimulus(1'b0, 10'h010, 64'h0, 1'b0, 8'h00);
      waitPops("t1_pops", base + 1 + WR_RSP, 20);
      checkOutput("t1_rdata", obsData[$], 64'hDEADBEEF_CAFEF00D);
      checkOutput("t1_ruser", obsUser[$], 1'b1);
      checkOutput("t1_latency", lastPopCycle - lastAccCycle, 2);

      $display("[TB] partial write then read back");
      base = popCount;
      applyStimulus(1'b1, 10'h010, 64'h11111111_22222222, 1'b0, 8'h0F);
      applyStimulus(1'b0, 10'h010, 64'h0, 1'b0, 8'h00);
      waitPops("t2_pops", base + 1 + WR_RSP, 20);
      checkOutput("t2_rdata", obsData[$], 64'hDEADBEEF_22222222);

      $display("[TB] backpressure limits outstanding reads");
      base = popCount;
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 10'h020 + 10'(i), 64'h1000 + 64'(i), 1'(i), 8'hFF);
      waitPops("t3_prefill_pops", base + 5 * WR_RSP, 20);
      rspReady = 1'b0;
      accBase = accCount;
      base = popCount;
      fork
         begin
            for (int i = 0; i < 5; i++)
               applyStimulus(1'b0, 10'h020 + 10'(i), 64'h0, 1'b0, 8'h00);
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            checkOutput("t3_accepted", accCount - accBase, 3);
            @(negedge clk);
            checkOutput("t3_ready_low", req_ready_o, 1'b0);
            @(posedge clk); #1;
            rspReady = 1'b1;
         end
      join
      waitPops("t3_pops", base + 5, 30);
      sz = obsData.size();
      for (int i = 0; i < 5; i++)
         checkOutput($sformatf("t3_order_%0d", i), obsData[sz - 5 + i], 64'h1000 + 64'(i));

      $display("[TB] streaming reads");
      base = popCount;
      accBase = stallCount;
      startCycle = cycle;
      for (int i = 0; i < 100; i++)
         applyStimulus(1'b0, 10'(i % 48), 64'h0, 1'b0, 8'h00);
      checkOutput("t4_cycles", cycle - startCycle, 100);
      checkOutput("t4_stalls", stallCount - accBase, 0);
      waitPops("t4_pops", base + 100, 20);
      checkOutput("t4_drain", lastPopCycle - lastAccCycle, 2);

      $display("[TB] reset with buffered and in-flight responses");
      rspReady = 1'b0;
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 10'h020 + 10'(i), 64'h0, 1'b0, 8'h00);
      rstI = 1'b1;
      @(posedge clk); #1;
      rstI = 1'b0;
      @(negedge clk);
      checkOutput("t5_rsp_valid", rsp_valid_o, 1'b0);
      checkOutput("t5_ready", req_ready_o, 1'b1);
      base = popCount;
      rspReady = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t5_no_stale", popCount, base);

`ifdef SRAM_BRIDGE_WRITE_RSP_EN
      $display("[TB] write response");
      base = popCount;
      applyStimulus(1'b1, 10'h040, 64'h55AA55AA_55AA55AA, 1'b1, 8'hFF);
      waitPops("t6_pops", base + 1, 20);
      checkOutput("t6_rsp_we", obsWe[$], 1'b1);
      checkOutput("t6_rsp_data", obsData[$], 64'h0);
`else
      $display("[TB] fire-and-forget writes under backpressure");
      rspReady = 1'b0;
      base = popCount;
      accBase = accCount;
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 10'h040 + 10'(i), 64'hA0 + 64'(i), 1'b0, 8'hFF);
      checkOutput("t6_accepted", accCount - accBase, 10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("t6_no_rsp", rsp_valid_o, 1'b0);
      rspReady = 1'b1;
      applyStimulus(1'b0, 10'h045, 64'h0, 1'b0, 8'h00);
      waitPops("t6_pops", base + 1, 20);
      checkOutput("t6_readback", obsData[$], 64'hA5);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
